// File: rtl/branch_predict_unit.sv
// Branch predictor: PC-indexed table of 2-bit saturating counters feeding a registered
// fetch prediction, plus an RV branch resolver that trains the table and counts events.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int PC_LSB      = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_out_valid,
  output logic             pred_taken,
  input  logic             branch,
  input  logic [2:0]       func3,
  input  logic [XLEN-1:0]  operand_a,
  input  logic [XLEN-1:0]  operand_b,
  input  logic [XLEN-1:0]  res_pc,
  input  logic             res_pred_taken,
  output logic             branch_taken,
  output logic             mispredict,
  output logic             illegal_op,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  // Handshake: a lookup is accepted on any edge with pred_valid=1 (no backpressure);
  // pred_out_valid marks pred_taken as fresh exactly one cycle later.

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cond_eq;
  logic             cond_lt_s;
  logic             cond_lt_u;
  logic             outcome;
  logic             legal;
  logic             illegal;
  logic             wrong_guess;
  logic             unused_pc_bits;

  assign pred_idx       = pred_pc[PC_LSB +: IDX_W];
  assign res_idx        = res_pc[PC_LSB +: IDX_W];
  // PC bits outside the index are intentionally ignored (aliasing is allowed).
  assign unused_pc_bits = ^{pred_pc, res_pc};

  assign cond_eq   = (operand_a == operand_b);
  assign cond_lt_s = ($signed(operand_a) < $signed(operand_b));
  assign cond_lt_u = (operand_a < operand_b);

  always_comb begin
    outcome = 1'b0;
    case (func3)
      3'b000:  outcome = cond_eq;
      3'b001:  outcome = !cond_eq;
      3'b100:  outcome = cond_lt_s;
      3'b101:  outcome = !cond_lt_s;
      3'b110:  outcome = cond_lt_u;
      3'b111:  outcome = !cond_lt_u;
      default: outcome = 1'b0;
    endcase
  end

  assign illegal      = branch && (func3[2:1] == 2'b01);
  assign legal        = branch && (func3[2:1] != 2'b01);
  assign branch_taken = legal && outcome;
  assign wrong_guess  = legal && (outcome != res_pred_taken);

  // Lookup reads the pre-update counter even when training hits the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
    end else begin
      pred_out_valid <= pred_valid;
      if (pred_valid) begin
        pred_taken <= bht[pred_idx][1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (legal) begin
      if (outcome && (bht[res_idx] != 2'b11)) begin
        bht[res_idx] <= bht[res_idx] + 2'b01;
      end else if (!outcome && (bht[res_idx] != 2'b00)) begin
        bht[res_idx] <= bht[res_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict       <= 1'b0;
      illegal_op       <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict <= wrong_guess;
      illegal_op <= illegal;
      if (legal && (branch_count != '1)) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (wrong_guess && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: a 32-bit-counter instance and a 4-bit-counter instance
// share stimulus and are checked against a table/integer reference model.
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        branch = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [31:0] res_pc = '0;
  logic        res_pred_taken = 1'b0;

  logic        pred_out_valid, pred_taken, branch_taken, mispredict, illegal_op;
  logic [31:0] branch_count, mispredict_count;
  logic        pred_out_valid_s, pred_taken_s, branch_taken_s, mispredict_s, illegal_op_s;
  logic [3:0]  branch_count_s, mispredict_count_s;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
    .branch(branch), .func3(func3), .operand_a(operand_a), .operand_b(operand_b),
    .res_pc(res_pc), .res_pred_taken(res_pred_taken), .branch_taken(branch_taken),
    .mispredict(mispredict), .illegal_op(illegal_op),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predict_unit #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(pred_out_valid_s), .pred_taken(pred_taken_s),
    .branch(branch), .func3(func3), .operand_a(operand_a), .operand_b(operand_b),
    .res_pc(res_pc), .res_pred_taken(res_pred_taken), .branch_taken(branch_taken_s),
    .mispredict(mispredict_s), .illegal_op(illegal_op_s),
    .branch_count(branch_count_s), .mispredict_count(mispredict_count_s)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ref_bht [64];
  longint      ref_branches;
  longint      ref_misp;
  logic [0:0]  exp_q [$];

  function automatic int ref_idx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic longint as_signed(input logic [31:0] v);
    longint u;
    u = longint'(v);
    return (u >= 64'sh8000_0000) ? u - 64'sh1_0000_0000 : u;
  endfunction

  function automatic logic ref_outcome(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub;
    ua = longint'(a);
    ub = longint'(b);
    case (f3)
      3'd0:    return ua == ub;
      3'd1:    return ua != ub;
      3'd4:    return as_signed(a) < as_signed(b);
      3'd5:    return as_signed(a) >= as_signed(b);
      3'd6:    return ua < ub;
      3'd7:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint sat(input longint v, input longint max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 64; i++) ref_bht[i] = 1;
    ref_branches = 0;
    ref_misp     = 0;
    exp_q.delete();
  endtask

  task automatic ref_train(input logic [31:0] pc, input logic taken);
    int k;
    k = ref_idx(pc);
    ref_bht[k] = taken ? ((ref_bht[k] + 1 > 3) ? 3 : ref_bht[k] + 1)
                       : ((ref_bht[k] - 1 < 0) ? 0 : ref_bht[k] - 1);
  endtask

  task automatic check_counts(input string name);
    logic [31:0] eb, em;
    logic [3:0]  ebs, ems;
    eb  = 32'(ref_branches);
    em  = 32'(ref_misp);
    ebs = 4'(sat(ref_branches, 15));
    ems = 4'(sat(ref_misp, 15));
    n_checks++;
    if ({branch_count, mispredict_count, branch_count_s, mispredict_count_s} !== {eb, em, ebs, ems})
      $display("FAIL %s counts: got %0d/%0d small %0d/%0d, expected %0d/%0d small %0d/%0d", name,
               branch_count, mispredict_count, branch_count_s, mispredict_count_s, eb, em, ebs, ems);
    else n_pass++;
  endtask

  task automatic do_resolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic pt, input string name);
    logic is_legal, exp_t, exp_mp, exp_il;
    is_legal = (f3 != 3'd2) && (f3 != 3'd3);
    exp_t    = is_legal && ref_outcome(f3, a, b);
    exp_mp   = is_legal && (exp_t != pt);
    exp_il   = !is_legal;
    branch = 1'b1; func3 = f3; operand_a = a; operand_b = b; res_pc = pc; res_pred_taken = pt;
    #1;
    n_checks++;
    if ({branch_taken, branch_taken_s} !== {exp_t, exp_t})
      $display("FAIL %s branch_taken: got %b expected %b", name, branch_taken, exp_t);
    else n_pass++;
    @(posedge clk);
    #1;
    if (is_legal) begin
      ref_train(pc, exp_t);
      ref_branches++;
      if (exp_mp) ref_misp++;
    end
    n_checks++;
    if ({mispredict, illegal_op, mispredict_s, illegal_op_s} !== {exp_mp, exp_il, exp_mp, exp_il})
      $display("FAIL %s pulses: got mp=%b il=%b expected mp=%b il=%b", name, mispredict, illegal_op, exp_mp, exp_il);
    else n_pass++;
    check_counts(name);
    branch = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc, input string name);
    logic exp_p;
    pred_valid = 1'b1;
    pred_pc    = pc;
    exp_q.push_back((ref_bht[ref_idx(pc)] >= 2) ? 1'b1 : 1'b0);
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    exp_p = exp_q.pop_front();
    n_checks++;
    if ({pred_out_valid, pred_taken, pred_out_valid_s, pred_taken_s} !== {1'b1, exp_p, 1'b1, exp_p})
      $display("FAIL %s lookup: got valid=%b taken=%b expected valid=1 taken=%b", name, pred_out_valid, pred_taken, exp_p);
    else n_pass++;
  endtask

  task automatic do_idle(input string name);
    @(posedge clk);
    #1;
    n_checks++;
    if ({pred_out_valid, mispredict, illegal_op, pred_out_valid_s, mispredict_s, illegal_op_s} !== 6'b0)
      $display("FAIL %s idle: got valid=%b mp=%b il=%b expected all 0", name, pred_out_valid, mispredict, illegal_op);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    ref_reset();
    n_checks++;
    if ({pred_out_valid, pred_taken, mispredict, illegal_op} !== 4'b0)
      $display("FAIL reset outputs: got %b expected 0000", {pred_out_valid, pred_taken, mispredict, illegal_op});
    else n_pass++;
    check_counts("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_lookup(32'h100, "reset_lookup");
    check_counts("reset_after_lookup");
    do_idle("reset_idle");
  endtask

  task automatic test_compare();
    do_resolve(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h1000, 1'b0, "blt_neg");
    do_resolve(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h1000, 1'b0, "bltu_big");
    do_resolve(3'b111, 32'd5, 32'd5, 32'h1000, 1'b1, "bgeu_eq");
    do_resolve(3'b001, 32'd7, 32'd7, 32'h1000, 1'b0, "bne_eq");
    do_resolve(3'b000, 32'd9, 32'd9, 32'h1000, 1'b1, "beq_eq");
    do_resolve(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1000, 1'b1, "bge_min");
    do_idle("compare_idle");
  endtask

  task automatic test_training();
    do_resolve(3'b000, 32'd3, 32'd3, 32'h40, 1'b0, "train_taken0");
    do_resolve(3'b000, 32'd3, 32'd3, 32'h40, 1'b0, "train_taken1");
    do_idle("train_pulse_end");
    do_lookup(32'h40, "train_strong_taken");
    for (int i = 0; i < 4; i++) do_resolve(3'b001, 32'd4, 32'd4, 32'h40, 1'b1, "train_nt");
    do_lookup(32'h40, "train_strong_nt");
    do_resolve(3'b000, 32'd1, 32'd1, 32'h40, 1'b0, "train_one_taken");
    do_lookup(32'h40, "train_weak_nt");
  endtask

  task automatic test_illegal();
    do_resolve(3'b010, 32'd5, 32'd5, 32'h40, 1'b1, "illegal_010");
    do_resolve(3'b011, 32'd5, 32'd6, 32'h40, 1'b0, "illegal_011");
    do_idle("illegal_idle");
    do_lookup(32'h40, "illegal_bht_kept");
  endtask

  task automatic test_same_edge();
    logic exp_p;
    exp_p = (ref_bht[ref_idx(32'h80)] >= 2) ? 1'b1 : 1'b0;
    pred_valid = 1'b1; pred_pc = 32'h80;
    branch = 1'b1; func3 = 3'b000; operand_a = 32'd2; operand_b = 32'd2;
    res_pc = 32'h80; res_pred_taken = 1'b1;
    @(posedge clk);
    #1;
    ref_train(32'h80, 1'b1);
    ref_branches++;
    pred_valid = 1'b0;
    branch = 1'b0;
    n_checks++;
    if ({pred_out_valid, pred_taken, mispredict} !== {1'b1, exp_p, 1'b0})
      $display("FAIL same_edge old_value: got valid=%b taken=%b mp=%b expected 1 %b 0", pred_out_valid, pred_taken, mispredict, exp_p);
    else n_pass++;
    check_counts("same_edge");
    do_lookup(32'h80, "same_edge_new_value");
  endtask

  task automatic test_random();
    logic [31:0] a, b, pc;
    for (int i = 0; i < 80; i++) begin
      pc = 32'($urandom_range(0, 7) * 4 + ($urandom_range(0, 3) << 8));
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = a; end
        1:       begin a = $urandom; b = a ^ 32'h8000_0000; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      case ($urandom_range(0, 5))
        0:       do_lookup(pc, "rand_lookup");
        1:       do_idle("rand_idle");
        default: do_resolve(3'($urandom_range(0, 7)), a, b, pc, 1'($urandom_range(0, 1)), "rand_resolve");
      endcase
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) do_resolve(3'b000, 32'd1, 32'd2, 32'h200, 1'b1, "sat_resolve");
    n_checks++;
    if ({branch_count_s, mispredict_count_s} !== 8'hFF)
      $display("FAIL saturation small: got %h/%h expected f/f", branch_count_s, mispredict_count_s);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_resolve(3'b000, 32'd0, 32'd0, 32'hC0, 1'b1, "mid_train0");
    do_resolve(3'b000, 32'd0, 32'd0, 32'hC0, 1'b1, "mid_train1");
    pred_valid = 1'b1; pred_pc = 32'hC0;
    branch = 1'b1; func3 = 3'b000; operand_a = 32'd1; operand_b = 32'd2;
    res_pc = 32'hC0; res_pred_taken = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({pred_out_valid, pred_taken, mispredict} !== 3'b111)
      $display("FAIL mid_inflight: got %b expected 111", {pred_out_valid, pred_taken, mispredict});
    else n_pass++;
    pred_valid = 1'b0;
    branch = 1'b0;
    #2 rst = 1'b1;
    #1;
    ref_reset();
    n_checks++;
    if ({pred_out_valid, pred_taken, mispredict, illegal_op, pred_out_valid_s, mispredict_s} !== 6'b0)
      $display("FAIL mid_reset outputs: got %b expected 000000",
               {pred_out_valid, pred_taken, mispredict, illegal_op, pred_out_valid_s, mispredict_s});
    else n_pass++;
    check_counts("mid_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    do_lookup(32'hC0, "mid_bht_reset");
  endtask

  initial begin
    test_reset();
    test_compare();
    test_training();
    test_illegal();
    test_same_edge();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
